// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle for bin_to_bcd_seq. The blank_mask signal exists
// only when BIN2BCD_BLANK_EN is defined.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0]     blank_mask;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out,
    input  blank_mask
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out,
    output blank_mask
  );
`else
  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out
  );
`endif
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Optional leading-zero blank mask output enabled by macro BIN2BCD_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic            clk,
  input  logic            rstn,
  bin_to_bcd_seq_if.slave bus
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CAT_W = ACC_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [ACC_W-1:0] w_acc_adj;
  logic [BIN_W-1:0] r_sreg;
  logic [BIN_W-1:0] w_sreg_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [ACC_W-1:0] r_bcd;
  logic [ACC_W-1:0] w_bcd_nxt;
  logic [CAT_W-1:0] w_cat_shl;
  logic             w_last_shift;

  function automatic logic [3:0] add3_if_ge5(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  // Per-digit correction applied before the shift
  always_comb begin
    w_acc_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_acc_adj[4*i +: 4] = add3_if_ge5(r_acc[4*i +: 4]);
    end
  end

  // The carry out of the top digit falls off here, giving the mod 10^DIGITS result
  assign w_cat_shl    = {w_acc_adj, r_sreg} << 1'b1;
  assign w_last_shift = (r_state == ST_SHIFT) && (r_cnt == CNT_ONE);

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_sreg_nxt  = r_sreg;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_bcd_nxt   = r_bcd;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_SHIFT;
          w_sreg_nxt  = bus.bin_in;
          w_acc_nxt   = '0;
          w_cnt_nxt   = CNT_LOAD;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      ST_SHIFT: begin
        w_acc_nxt  = w_cat_shl[CAT_W-1 -: ACC_W];
        w_sreg_nxt = w_cat_shl[BIN_W-1:0];
        w_cnt_nxt  = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = ST_IDLE;
          w_bcd_nxt   = w_cat_shl[CAT_W-1 -: ACC_W];
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_SHIFT;
          w_busy_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_acc  <= '0;
      r_sreg <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_bcd  <= '0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_sreg <= w_sreg_nxt;
      r_cnt  <= w_cnt_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_bcd  <= w_bcd_nxt;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.bcd_out = r_bcd;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank_nxt;
  logic [DIGITS-1:0] w_blank_res;
  logic              w_zero_run;

  // Leading-zero flags scanned from the top digit down; units digit never blanks
  always_comb begin
    w_blank_res = '0;
    w_zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_run     = w_zero_run & (w_cat_shl[BIN_W + 4*i +: 4] == 4'd0);
      w_blank_res[i] = w_zero_run;
    end
  end

  // Blank mask captured together with the result
  always_comb begin
    if (w_last_shift) begin
      w_blank_nxt = w_blank_res;
    end else begin
      w_blank_nxt = r_blank;
    end
  end

  // Blank mask register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_blank <= '0;
    end else begin
      r_blank <= w_blank_nxt;
    end
  end

  assign bus.blank_mask = r_blank;
`endif

endmodule
